// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int ON_CYCLES  = 1000,
    parameter int GAP_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank,
    output logic [3:0]              nibble_out,
    input  logic [7:0]              seg_in,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    load_pending,
    output logic                    frame_tick,
    output logic [0:0]              dbg_state
);

    localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    localparam logic [0:0] S_GAP  = 1'b0;
    localparam logic [0:0] S_SHOW = 1'b1;

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("NUM_DIGITS must be in 2..8");
    end
    if (ON_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_cycles
        $error("ON_CYCLES and GAP_CYCLES must be >= 1");
    end

    logic [0:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;

    logic [4*NUM_DIGITS-1:0] committed_val;
    logic [NUM_DIGITS-1:0]   committed_dp;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic                    on_last;
    logic                    gap_last;
    logic                    wrap;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   suppress;

    assign dbg_state = state;

    always_comb begin
        on_last  = (cnt == ON_LAST);
        gap_last = (cnt == GAP_LAST);
        wrap     = (state == S_GAP) && gap_last && (idx == IDX_LAST);
    end

    // Scan sequencer: SHOW for ON_CYCLES, GAP for GAP_CYCLES, then next digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_GAP;
            cnt   <= '0;
            idx   <= IDX_LAST;
        end else begin
            case (state)
                S_SHOW: begin
                    if (on_last) begin
                        state <= S_GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (gap_last) begin
                        state <= S_SHOW;
                        cnt   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // load is a one-cycle strobe with no back-pressure: it always lands in the
    // shadow; the shadow reaches the display only on the wrap to digit 0, and a
    // load coinciding with that wrap commits the older shadow and stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            committed_val <= '0;
            committed_dp  <= '0;
            shadow_val    <= '0;
            shadow_dp     <= '0;
            load_pending  <= 1'b0;
        end else begin
            if (wrap && load_pending) begin
                committed_val <= shadow_val;
                committed_dp  <= shadow_dp;
            end
            if (load) begin
                shadow_val   <= value;
                shadow_dp    <= dp_in;
                load_pending <= 1'b1;
            end else if (wrap) begin
                load_pending <= 1'b0;
            end
        end
    end

    assign nibble_out = committed_val[4*int'(idx) +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic higher_zero;

    // Walk from the most significant digit down; digit 0 is never suppressed.
    always_comb begin
        higher_zero = 1'b1;
        suppress    = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            higher_zero = higher_zero & (committed_val[4*i +: 4] == 4'h0);
            suppress[i] = higher_zero & ~committed_dp[i];
        end
    end
`else
    assign suppress = '0;
`endif

    assign lit = (state == S_SHOW) && !blank && !suppress[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_n    <= '1;
            seg_out    <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            anode_n    <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg_out    <= lit ? {~committed_dp[idx], seg_in[6:0]} : 8'hFF;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with a frame-position reference model.
// Follows LEADING_ZERO_BLANK_EN the same way as the design.
module tb_seven_seg_scan_ctrl;

    localparam int N    = 4;
    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int SLOT = ON + GAP;
    localparam int F    = N * SLOT;
    // Release from reset lands at the start of the last digit's gap.
    localparam int BASE = (N - 1) * SLOT + ON;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic [15:0]  value = '0;
    logic [3:0]   dp_in = '0;
    logic         blank = 1'b0;
    logic [3:0]   nibble_out;
    logic [7:0]   seg_in;
    logic [7:0]   seg_out;
    logic [3:0]   anode_n;
    logic         load_pending;
    logic         frame_tick;
    logic [0:0]   dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    logic [17:0] exp_q[$];

    int          k;
    logic [15:0] m_com, m_sh;
    logic [3:0]  m_cdp, m_sdp;
    logic        m_pend;
    logic        last_wrap;

    logic [7:0]  cap_seg[N];
    logic        cap_seen[N];

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .ON_CYCLES(ON), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .blank(blank), .nibble_out(nibble_out), .seg_in(seg_in), .seg_out(seg_out),
        .anode_n(anode_n), .load_pending(load_pending), .frame_tick(frame_tick),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dec(input logic [3:0] n);
        case (n)
            4'h0: dec = 8'hC0; 4'h1: dec = 8'hF9; 4'h2: dec = 8'hA4; 4'h3: dec = 8'hB0;
            4'h4: dec = 8'h99; 4'h5: dec = 8'h92; 4'h6: dec = 8'h82; 4'h7: dec = 8'hF8;
            4'h8: dec = 8'h80; 4'h9: dec = 8'h90; 4'hA: dec = 8'h88; 4'hB: dec = 8'h83;
            4'hC: dec = 8'hC6; 4'hD: dec = 8'hA1; 4'hE: dec = 8'h86; default: dec = 8'h8E;
        endcase
    endfunction

    assign seg_in = dec(nibble_out);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic suppressed(input int d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d != 0) && ((m_com >> (4 * d)) == 16'h0) && !m_cdp[d];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        k = 0; m_com = '0; m_sh = '0; m_cdp = '0; m_sdp = '0;
        m_pend = 1'b0; last_wrap = 1'b0;
    endtask

    // Predict outputs after the coming edge from the frame position and inputs.
    task automatic step();
        int pc, pn, d;
        logic lit, wrap;
        logic [3:0] an, nib;
        logic [7:0] seg, pat;
        pc  = (BASE + k) % F;
        d   = pc / SLOT;
        lit = ((pc % SLOT) < ON) && !blank && !suppressed(d);
        pat = dec(m_com[4*d +: 4]);
        an  = lit ? ~(4'b0001 << d) : 4'hF;
        seg = lit ? {~m_cdp[d], pat[6:0]} : 8'hFF;
        pn   = (BASE + k + 1) % F;
        wrap = (pn == 0);
        if (wrap && m_pend) begin
            m_com = m_sh; m_cdp = m_sdp; m_pend = 1'b0;
        end
        if (load) begin
            m_sh = value; m_sdp = dp_in; m_pend = 1'b1;
        end
        nib = m_com[4*(pn / SLOT) +: 4];
        exp_q.push_back({nib, wrap, m_pend, an, seg});
        k++;
        last_wrap = wrap;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [17:0] e;
            e = exp_q.pop_front();
            chk("nibble_out",   32'(nibble_out),   32'(e[17:14]));
            chk("frame_tick",   32'(frame_tick),   32'(e[13]));
            chk("load_pending", 32'(load_pending), 32'(e[12]));
            chk("anode_n",      32'(anode_n),      32'(e[11:8]));
            chk("seg_out",      32'(seg_out),      32'(e[7:0]));
        end
    end

    task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] dp, input logic blk);
        load = ld; value = v; dp_in = dp; blank = blk;
        step();
        @(negedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, value, dp_in, 1'b0);
    endtask

    task automatic run_to_wrap();
        int i;
        i = 0;
        last_wrap = 1'b0;
        while (!last_wrap && i < 2 * F) begin
            cycle(1'b0, value, dp_in, 1'b0);
            i++;
        end
        if (!last_wrap) chk("wrap_timeout", 32'(i), 32'(2 * F));
    endtask

    task automatic capture_frame();
        for (int d = 0; d < N; d++) begin
            cap_seg[d] = 8'h00; cap_seen[d] = 1'b0;
        end
        for (int i = 0; i < F; i++) begin
            cycle(1'b0, value, dp_in, 1'b0);
            for (int d = 0; d < N; d++) begin
                if (anode_n == ~(4'b0001 << d)) begin
                    cap_seg[d] = seg_out; cap_seen[d] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int guard;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_anode", 32'(anode_n), 32'hF);
        chk("rst_seg",   32'(seg_out), 32'hFF);
        chk("rst_pend",  32'(load_pending), 32'h0);
        chk("rst_tick",  32'(frame_tick), 32'h0);
        rst_n = 1'b1;

        // Idle scan: first tick two edges after release, then every 24.
        for (int i = 1; i <= 30; i++) begin
            cycle(1'b0, 16'h0, 4'h0, 1'b0);
            if (i == 1)  chk("tick_k1",  32'(frame_tick), 32'h0);
            if (i == 2)  chk("tick_k2",  32'(frame_tick), 32'h1);
            if (i == 3)  chk("an_k3",    32'(anode_n), 32'hE);
            if (i == 3)  chk("seg_k3",   32'(seg_out), 32'hC0);
            if (i == 7)  chk("an_k7",    32'(anode_n), 32'hF);
            if (i == 9)  chk("an_k9",    32'(anode_n), 32'hD);
            if (i == 26) chk("tick_k26", 32'(frame_tick), 32'h1);
        end

        cycle(1'b1, 16'h12AF, 4'b0100, 1'b0);
        chk("pend_after_load", 32'(load_pending), 32'h1);
        run_to_wrap();
        chk("pend_after_wrap", 32'(load_pending), 32'h0);
        capture_frame();
        chk("t2_d0", 32'(cap_seg[0]), 32'h8E);
        chk("t2_d1", 32'(cap_seg[1]), 32'h88);
        chk("t2_d2", 32'(cap_seg[2]), 32'h24);
        chk("t2_d3", 32'(cap_seg[3]), 32'hF9);

        idle(3);
        cycle(1'b1, 16'h1111, 4'h0, 1'b0);
        idle(2);
        cycle(1'b1, 16'h2222, 4'h0, 1'b0);
        run_to_wrap();
        chk("t3_pend", 32'(load_pending), 32'h0);
        capture_frame();
        for (int d = 0; d < N; d++) chk("t3_digit", 32'(cap_seg[d]), 32'hA4);

        // Load on the wrap edge: older shadow commits, new one stays pending.
        cycle(1'b1, 16'h3333, 4'h0, 1'b0);
        guard = 0;
        while (((BASE + k + 1) % F) != 0 && guard < F) begin
            idle(1); guard++;
        end
        cycle(1'b1, 16'h4444, 4'h0, 1'b0);
        chk("t4_tick", 32'(frame_tick), 32'h1);
        chk("t4_pend", 32'(load_pending), 32'h1);
        capture_frame();
        chk("t4_first", 32'(cap_seg[2]), 32'hB0);
        capture_frame();
        chk("t4_second", 32'(cap_seg[2]), 32'h99);

        // Blank for 10 cycles starting inside digit 1's lit slot.
        guard = 0;
        while (!((((BASE + k) % F) / SLOT == 1) && (((BASE + k) % F) % SLOT == 1)) && guard < F) begin
            idle(1); guard++;
        end
        cycle(1'b0, value, dp_in, 1'b1);
        chk("t5_blank_an",  32'(anode_n), 32'hF);
        chk("t5_blank_seg", 32'(seg_out), 32'hFF);
        for (int i = 0; i < 9; i++) cycle(1'b0, value, dp_in, 1'b1);
        idle(F);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic ld, blk;
            ld  = ($urandom_range(0, 19) == 0);
            blk = blank;
            if ($urandom_range(0, 14) == 0) blk = ~blank;
            cycle(ld, 16'($urandom), 4'($urandom), blk);
        end
        idle(2);

        // Asynchronous reset while digit 2 is lit.
        guard = 0;
        while (!((((BASE + k) % F) / SLOT == 2) && (((BASE + k) % F) % SLOT == 2)) && guard < F) begin
            idle(1); guard++;
        end
        chk("t6_lit_before", 32'(anode_n), 32'hB);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_anode", 32'(anode_n), 32'hF);
        chk("t6_rst_seg",   32'(seg_out), 32'hFF);
        chk("t6_rst_pend",  32'(load_pending), 32'h0);
        chk("t6_rst_tick",  32'(frame_tick), 32'h0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 16'h0007, 4'h0, 1'b0);
        run_to_wrap();
        capture_frame();
`ifdef LEADING_ZERO_BLANK_EN
        chk("t6_d3_off", 32'(cap_seen[3]), 32'h0);
        chk("t6_d2_off", 32'(cap_seen[2]), 32'h0);
        chk("t6_d1_off", 32'(cap_seen[1]), 32'h0);
`else
        chk("t6_d1_on",  32'(cap_seg[1]), 32'hC0);
        chk("t6_d3_on",  32'(cap_seg[3]), 32'hC0);
`endif
        chk("t6_d0", 32'(cap_seg[0]), 32'hF8);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
